// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter and sequencer for the unified instruction/data memory
module mem_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        memory_write,
  output logic [1:0]  memory_size,
  output logic [31:0] memory_addr,
  output logic [31:0] memory_data_in,
  input  logic [31:0] memory_data_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_NOP  = 2'b11;

  state_t            state_q, state_d;
  logic [3:0]        starve_q;
  logic              own_if_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              we_q;
  logic              uns_q;
  logic [31:0]       wdata_q;
  logic              if_rvalid_q, d_rvalid_q, d_err_q;
  logic              fetch_first;
  logic              unused_addr_bits;

  // Only the low ADDR_W address bits reach the memory; fetch bit 0 is always cleared.
  assign unused_addr_bits = ^{if_addr[31:ADDR_W], if_addr[0], d_addr[31:ADDR_W]};

  // State register: IDLE -> ISSUE -> RESP, with back-to-back accesses looping RESP -> ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Grant selection, next state and memory command drive.
  always_comb begin
    if_gnt         = 1'b0;
    d_gnt          = 1'b0;
    state_d        = state_q;
    memory_write   = 1'b0;
    memory_size    = SIZE_NOP;
    memory_addr    = 32'd0;
    memory_data_in = 32'd0;
    // Data has priority unless fetch has been passed over STARVE_LIMIT times in a row.
    fetch_first    = if_req && (!d_req || (starve_q == LIMIT));
    case (state_q)
      IDLE, RESP: begin
        if (!rst) begin
          if_gnt = fetch_first;
          d_gnt  = d_req && !fetch_first;
        end
        state_d = (if_gnt || d_gnt) ? ISSUE : IDLE;
      end
      ISSUE: begin
        state_d        = RESP;
        memory_addr    = 32'(addr_q);
        memory_data_in = wdata_q;
        // An illegal size keeps the memory in its no-op encoding.
        if (size_q != SIZE_NOP) begin
          memory_write = we_q;
          memory_size  = size_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Starvation counter: counts data grants that overtook a waiting fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= 4'd0;
    end else if (if_gnt || !if_req) begin
      starve_q <= 4'd0;
    end else if (d_gnt && (starve_q != LIMIT)) begin
      starve_q <= starve_q + 4'd1;
    end
  end

  // Capture the granted command so the requester may move on immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_if_q <= 1'b0;
      addr_q   <= '0;
      size_q   <= SIZE_NOP;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      wdata_q  <= 32'd0;
    end else if (if_gnt) begin
      own_if_q <= 1'b1;
      addr_q   <= {if_addr[ADDR_W-1:1], 1'b0};
      size_q   <= SIZE_WORD;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      wdata_q  <= 32'd0;
    end else if (d_gnt) begin
      own_if_q <= 1'b0;
      addr_q   <= d_addr[ADDR_W-1:0];
      size_q   <= d_size;
      we_q     <= d_we;
      uns_q    <= d_unsigned;
      wdata_q  <= d_wdata;
    end
  end

  // Completion flags: set on the edge that leaves ISSUE, so they pulse for the RESP cycle only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      if_rvalid_q <= (state_q == ISSUE) && own_if_q;
      d_rvalid_q  <= (state_q == ISSUE) && !own_if_q;
      d_err_q     <= (state_q == ISSUE) && !own_if_q && (size_q == SIZE_NOP);
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_err     = d_err_q;

  // Response data: memory read-data is registered in the memory, so it is valid in RESP;
  // byte/half loads drop the stale upper bytes and are extended.
  always_comb begin
    if_rdata = 32'd0;
    d_rdata  = 32'd0;
    if (if_rvalid_q) if_rdata = memory_data_out;
    if (d_rvalid_q && !d_err_q && !we_q) begin
      case (size_q)
        SIZE_BYTE: d_rdata = uns_q ? {24'd0, memory_data_out[7:0]}
                                   : {{24{memory_data_out[7]}}, memory_data_out[7:0]};
        SIZE_HALF: d_rdata = uns_q ? {16'd0, memory_data_out[15:0]}
                                   : {{16{memory_data_out[15]}}, memory_data_out[15:0]};
        default:   d_rdata = memory_data_out;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer in front of the unified single-port, byte-addressed 4 KiB instruction/data memory of the RV32IC core. It accepts instruction fetches and data loads/stores and serialises them onto the memory's one command port (write, size, address, write-data, registered read-data). It also cleans up load data: it masks the stale upper bits the memory leaves on byte and halfword reads and applies sign or zero extension. Priority goes to the data port, with a starvation guard for fetch.

## Interface
- `ADDR_W`, default 12: memory address bits forwarded; upper bits of `memory_addr` driven 0.
- `STARVE_LIMIT`, default 4: consecutive data grants with fetch pending before fetch is forced ahead; range 1..15.
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch request; held until granted.
- `if_addr` in 32: fetch byte address; bit 0 forced to 0.
- `if_gnt` out 1: fetch accepted this cycle (combinational).
- `if_rvalid` out 1: one-cycle pulse; `if_rdata` valid.
- `if_rdata` out 32: 32-bit fetch word, little-endian from the fetch address.
- `d_req` in 1: data request; held until granted.
- `d_we` in 1: 1 means store, 0 means load.
- `d_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `d_unsigned` in 1: load zero-extends when 1, sign-extends when 0.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data, low-aligned.
- `d_gnt` out 1: data accepted this cycle (combinational).
- `d_rvalid` out 1: one-cycle completion pulse for loads and stores.
- `d_rdata` out 32: extended load data; 0 for stores.
- `d_err` out 1: qualifies `d_rvalid`; set for `d_size` 11.
- `memory_write` out 1: to memory.
- `memory_size` out 2: to memory.
- `memory_addr` out 32: to memory.
- `memory_data_in` out 32: to memory.
- `memory_data_out` in 32: from memory; valid the cycle after the sampling edge.

## Operation
- **FSM states:** IDLE, ISSUE, RESP.
  - IDLE: accept a request, then go to ISSUE; with no request, stay in IDLE.
  - ISSUE: drive the memory command; always go to RESP on the next edge.
  - RESP: pulse `rvalid` for the owner. Also accept a new request: go to ISSUE if one is granted, otherwise to IDLE.
- **Grant conditions:** grants are possible only in IDLE or RESP and only while `rst` is low. At most one of `if_gnt`/`d_gnt` is high in any cycle.
- **Selection:**
  - Data wins when both requests are present.
  - Exception: when the starvation counter equals `STARVE_LIMIT`, fetch wins.
- **Starvation counter (4 bits):**
  - Increments on each `d_gnt` while `if_req` is high and `if_gnt` is low.
  - Clears on `if_gnt`, or when `if_req` is low.
  - Saturates at `STARVE_LIMIT`.
- **Captured command:** on a grant, latch the owner, address (bit 0 cleared for fetch), size (10 for fetch), we (0 for fetch), wdata, and `d_unsigned`.
- **ISSUE drive:**
  - `memory_addr` = {zeros, addr[ADDR_W-1:0]}.
  - `memory_size` = captured size.
  - `memory_write` = we.
  - `memory_data_in` = wdata.
- **Illegal size (`d_size` 11):** no memory access. ISSUE drives `memory_write` = 0 and `memory_size` = 11. RESP gives `d_rvalid` = 1, `d_err` = 1, `d_rdata` = 0.
- **Outside ISSUE:** `memory_write` = 0 and `memory_size` = 11, a memory no-op that keeps `memory_data_out` stable.
- **RESP load data:**
  - Byte: `memory_data_out[7:0]` extended from bit 7, or zero-extended.
  - Half: bits [15:0] extended from bit 15, or zero-extended.
  - Word: passed through unchanged.
  - Fetch: the word is passed through to `if_rdata`.
- **Stores:** `d_rvalid` pulses in RESP with `d_rdata` = 0 and `d_err` = 0.
- **Address range:** addresses whose access spans beyond 2^ADDR_W − 1 return undefined bytes. No wrap is applied and no error is flagged.

## Timing
- **Reset values:**
  - State IDLE, counter 0.
  - `if_gnt`, `d_gnt`, `if_rvalid`, `d_rvalid`, `d_err` = 0.
  - `if_rdata`, `d_rdata` = 0.
  - `memory_write` = 0, `memory_size` = 11, `memory_addr` = 0, `memory_data_in` = 0.
- **Latency:** request granted in cycle N, memory driven in N+1 (memory samples at end of N+1), `rvalid` in N+2. Sustained throughput is one access per 2 cycles.
- **Output registration:** `rvalid`, `rdata`, and `err` are registered; each holds for exactly one cycle. `rdata` returns to 0 after the pulse.
- **Requester rules:** `req` and its fields must stay stable until `gnt`. A requester may re-request in the same cycle as its `rvalid`; that request can be granted in that RESP cycle.
- **Reset mid-operation:** an outstanding command is discarded and no `rvalid` is produced. If reset hits during ISSUE with a store, `memory_write` drops immediately because reset is asynchronous; whether that store is performed is undefined.
- **Simultaneous events:** requests from both ports in RESP follow the same priority/starvation rule as in IDLE.

## Test plan
- **Word store then load:** store `d_addr` 0x010, `d_wdata` 0xDEADBEEF, then load a word from 0x010. Response: `d_rvalid` 2 cycles after each grant, and the load gives `d_rdata` 0xDEADBEEF.
- **Byte/half extension:**
  - Memory 0x020 = 0x80, signed byte load: `d_rdata` 0xFFFFFF80.
  - Same byte, `d_unsigned` = 1: 0x00000080.
  - Memory at 0x022 = 0x8001, signed half load: 0xFFFF8001.
- **Conflict with `STARVE_LIMIT` = 4:** hold `if_req` and `d_req` continuously high. Response: 4 data grants, then 1 fetch grant, then the pattern repeats; grants never overlap.
- **Fetch alignment:** fetch at 0x006 with bytes 0x006..0x009 = 11 22 33 44. Response: `if_rdata` 0x44332211. Fetch at 0x007 behaves identically (bit 0 cleared).
- **Illegal size:** load with `d_size` 11. Response: `memory_size` stays 11 and `memory_write` stays 0 throughout; `d_rvalid` = `d_err` = 1 with `d_rdata` 0.
- **Reset during ISSUE of a fetch:** all outputs return to their reset values while `rst` is high. No `if_rvalid` follows, and the next request is granted from IDLE.
